// File: rtl/tm1638_display_ctrl.sv
`default_nettype none
// ============================================================================
// tm1638_display_ctrl: hex/BCD value to TM1638 7-segment frame writer
// Revision: 1.0
// ============================================================================
module tm1638_display_ctrl #(
    parameter int N_DIGITS = 3,
    parameter int CLK_DIV  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     leds,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    input  logic                    blank_lz,
    input  logic                    req,
    output logic                    busy,
    output logic                    done,
    output logic                    out_clk_1,
    output logic                    strobe,
    output logic                    dio
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD1 = 3'd1,
        S_GAP1 = 3'd2,
        S_CMD2 = 3'd3,
        S_GAP2 = 3'd4,
        S_CMD3 = 3'd5,
        S_GAP3 = 3'd6
    } state_t;

    state_t                r_state;
    logic [DW-1:0]         r_div;
    logic                  r_phase;     // 0 = CLK low half, 1 = CLK high half
    logic [2:0]            r_bit;
    logic [4:0]            r_byte;

    logic [4*N_DIGITS-1:0] r_value;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_leds;
    logic [2:0]            r_bright;
    logic                  r_on;
    logic                  r_blank_lz;

    logic [7:0]            w_seg   [N_DIGITS];
    logic [7:0]            w_frame [17];
    logic [7:0]            w_ctrl;
    logic [7:0]            w_cur_byte;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Walk from the most significant digit down; zeros stay blank until the first non-zero nibble.
    always_comb begin : seg_encode
        logic       lz;
        logic [3:0] nib;
        lz  = r_blank_lz;
        nib = 4'd0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            nib = r_value[4*d +: 4];
            if (nib != 4'd0) lz = 1'b0;
            w_seg[d] = {r_dp[d], (lz && d != 0) ? 7'h00 : hex7(nib)};
        end
    end

    // Frame byte 0 is the address command, bytes 1..16 are TM1638 addresses 0..15.
    assign w_frame[0] = 8'hC0;
    for (genvar a = 0; a < 16; a++) begin : g_addr
        if ((a / 2) < N_DIGITS) begin : g_grid
            if ((a % 2) == 0) begin : g_seg
                assign w_frame[a+1] = w_seg[N_DIGITS-1-a/2];
            end else begin : g_led
                assign w_frame[a+1] = {7'b0, r_leds[N_DIGITS-1-a/2]};
            end
        end else begin : g_blank
            assign w_frame[a+1] = 8'h00;
        end
    end

    assign w_ctrl = {4'b1000, r_on, r_bright};

    always_comb begin
        w_cur_byte = w_ctrl;
        if (r_state == S_CMD1)      w_cur_byte = 8'h40;
        else if (r_state == S_CMD2) w_cur_byte = w_frame[r_byte];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_phase    <= 1'b0;
            r_bit      <= 3'd0;
            r_byte     <= 5'd0;
            r_value    <= '0;
            r_dp       <= '0;
            r_leds     <= '0;
            r_bright   <= 3'd0;
            r_on       <= 1'b0;
            r_blank_lz <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_clk_1  <= 1'b1;
            strobe     <= 1'b1;
            dio        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_value    <= value;
                        r_dp       <= dp;
                        r_leds     <= leds;
                        r_bright   <= brightness;
                        r_on       <= display_on;
                        r_blank_lz <= blank_lz;
                        r_state    <= S_CMD1;
                        busy       <= 1'b1;
                        strobe     <= 1'b0;
                        out_clk_1  <= 1'b0;
                        dio        <= 1'b0;     // bit 0 of 0x40
                    end
                end
                S_CMD1, S_CMD2, S_CMD3: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase   <= 1'b1;
                            out_clk_1 <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (r_bit != 3'd7) begin
                                r_bit     <= r_bit + 3'd1;
                                out_clk_1 <= 1'b0;
                                dio       <= w_cur_byte[r_bit + 3'd1];
                            end else begin
                                r_bit <= 3'd0;
                                if (r_state == S_CMD2 && r_byte != 5'd16) begin
                                    r_byte    <= r_byte + 5'd1;
                                    out_clk_1 <= 1'b0;
                                    dio       <= w_frame[r_byte + 5'd1][0];
                                end else begin
                                    r_byte <= 5'd0;
                                    strobe <= 1'b1;
                                    dio    <= 1'b1;
                                    if (r_state == S_CMD1)      r_state <= S_GAP1;
                                    else if (r_state == S_CMD2) r_state <= S_GAP2;
                                    else                        r_state <= S_GAP3;
                                end
                            end
                        end
                    end
                end
                S_GAP1, S_GAP2, S_GAP3: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (r_state == S_GAP3) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            strobe    <= 1'b0;
                            out_clk_1 <= 1'b0;
                            if (r_state == S_GAP1) begin
                                r_state <= S_CMD2;
                                dio     <= w_frame[0][0];
                            end else begin
                                r_state <= S_CMD3;
                                dio     <= w_ctrl[0];
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tm1638_display_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tm1638_display_ctrl: bench for tm1638_display_ctrl (3-digit and 8-digit)
// Revision: 1.0
// ============================================================================
module tb_tm1638_display_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // 3-digit, CLK_DIV=2 instance
    logic        rst3, req3, on3, blz3;
    logic [11:0] v3;
    logic [2:0]  dp3, led3, br3;
    logic        busy3, done3, sclk3, stb3, dio3;

    // 8-digit, CLK_DIV=1 instance
    logic        rst8, req8, on8, blz8;
    logic [31:0] v8;
    logic [7:0]  dp8, led8;
    logic [2:0]  br8;
    logic        busy8, done8, sclk8, stb8, dio8;

    tm1638_display_ctrl #(.N_DIGITS(3), .CLK_DIV(2)) dut3 (
        .clk(clk), .rst(rst3), .value(v3), .dp(dp3), .leds(led3), .brightness(br3),
        .display_on(on3), .blank_lz(blz3), .req(req3), .busy(busy3), .done(done3),
        .out_clk_1(sclk3), .strobe(stb3), .dio(dio3)
    );

    tm1638_display_ctrl #(.N_DIGITS(8), .CLK_DIV(1)) dut8 (
        .clk(clk), .rst(rst8), .value(v8), .dp(dp8), .leds(led8), .brightness(br8),
        .display_on(on8), .blank_lz(blz8), .req(req8), .busy(busy8), .done(done8),
        .out_clk_1(sclk8), .strobe(stb8), .dio(dio8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic       m_valid  [2] = '{1'b0, 1'b0};
    logic       m_active [2] = '{1'b0, 1'b0};
    logic       m_done   [2] = '{1'b0, 1'b0};
    int         m_t      [2] = '{0, 0};
    logic [7:0] m_bytes  [2][19];

    // Byte idx of the whole frame: 0 = 0x40, 1 = 0xC0, 2..17 = addresses 0..15, 18 = control
    function automatic logic [7:0] model_byte(input int idx, input logic [31:0] val,
                                              input logic [7:0] dpv, input logic [7:0] ledv,
                                              input logic [2:0] br, input logic on,
                                              input logic blz, input int n);
        int a, g, d;
        logic [3:0] nib;
        logic blank;
        if (idx == 0)  return 8'h40;
        if (idx == 1)  return 8'hC0;
        if (idx == 18) return 8'h80 | {4'b0, on, br};
        a = idx - 2;
        g = a / 2;
        if (g >= n) return 8'h00;
        d = n - 1 - g;
        if (a % 2 == 1) return {7'b0, ledv[d]};
        nib   = val[4*d +: 4];
        blank = blz && (d != 0) && ((val >> (4*d)) == 32'd0);
        return (blank ? 8'h00 : hex_tab[nib]) | {dpv[d], 7'b0};
    endfunction

    // {strobe, clk, dio} for cycle t of a frame, from the frame timeline
    function automatic logic [2:0] frame_pins(input int k, input int t, input int d);
        int start, first, o, bp, bi, bn;
        logic high;
        if (t < 16*d)       begin start = 0;      first = 0;  end
        else if (t < 17*d)  return 3'b111;
        else if (t < 289*d) begin start = 17*d;   first = 1;  end
        else if (t < 290*d) return 3'b111;
        else if (t < 306*d) begin start = 290*d;  first = 18; end
        else                return 3'b111;
        o    = t - start;
        bp   = o / (2*d);
        bi   = first + bp / 8;
        bn   = bp % 8;
        high = (o % (2*d)) >= d;
        return {1'b0, high, m_bytes[k][bi][bn]};
    endfunction

    task automatic model_step(input int k, input logic r, input logic rq, input logic [31:0] val,
                              input logic [7:0] dpv, input logic [7:0] ledv, input logic [2:0] br,
                              input logic on, input logic blz, input int n, input int d);
        if (r) begin
            m_valid[k]  = 1'b1;
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
        end else if (m_active[k]) begin
            if (m_t[k] == 307*d - 1) begin
                m_active[k] = 1'b0;
                m_done[k]   = 1'b1;
            end else begin
                m_t[k]++;
            end
        end else begin
            m_done[k] = 1'b0;
            if (rq) begin
                m_active[k] = 1'b1;
                m_t[k]      = 0;
                for (int i = 0; i < 19; i++)
                    m_bytes[k][i] = model_byte(i, val, dpv, ledv, br, on, blz, n);
            end
        end
    endtask

    task automatic compare_pins(input int k, input int d, input logic [4:0] act, input string name);
        logic [4:0] exp;
        if (!m_valid[k]) return;
        if (m_active[k]) exp = {1'b1, 1'b0, frame_pins(k, m_t[k], d)};
        else             exp = {1'b0, m_done[k], 3'b111};
        check(name, act, exp);
    endtask

    always @(posedge clk) begin
        model_step(0, rst3, req3, {20'b0, v3}, {5'b0, dp3}, {5'b0, led3}, br3, on3, blz3, 3, 2);
        model_step(1, rst8, req8, v8, dp8, led8, br8, on8, blz8, 8, 1);
    end

    // ---------------- busy-length tracking and serial decoders ----------------
    int bl_cnt [2] = '{0, 0};
    int bl_last[2] = '{0, 0};
    int dn_cnt [2] = '{0, 0};

    task automatic track(input int k, input logic b, input logic dn);
        if (b) bl_cnt[k]++;
        else begin
            if (dn) begin
                bl_last[k] = bl_cnt[k];
                dn_cnt[k]++;
            end
            bl_cnt[k] = 0;
        end
    endtask

    logic [7:0] q3[$];
    logic [7:0] q8[$];
    logic [7:0] sh3, sh8;
    int         bits3 = 0, bits8 = 0;
    logic       prev3 = 1'b1, prev8 = 1'b1;

    always @(negedge clk) begin
        compare_pins(0, 2, {busy3, done3, stb3, sclk3, dio3}, "d3_pins");
        track(0, busy3, done3);
        if (stb3 !== 1'b0) bits3 = 0;
        else if (sclk3 === 1'b1 && prev3 === 1'b0) begin
            sh3 = {dio3, sh3[7:1]};
            bits3++;
            if (bits3 == 8) begin q3.push_back(sh3); bits3 = 0; end
        end
        prev3 = sclk3;
    end

    always @(negedge clk) begin
        compare_pins(1, 1, {busy8, done8, stb8, sclk8, dio8}, "d8_pins");
        track(1, busy8, done8);
        if (stb8 !== 1'b0) bits8 = 0;
        else if (sclk8 === 1'b1 && prev8 === 1'b0) begin
            sh8 = {dio8, sh8[7:1]};
            bits8++;
            if (bits8 == 8) begin q8.push_back(sh8); bits8 = 0; end
        end
        prev8 = sclk8;
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] exp123 [19] = '{8'h40, 8'hC0, 8'h06, 8'h00, 8'h5B, 8'h00, 8'h4F, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h8F};
    logic [7:0] exp8grid [8] = '{8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [7:0] q3_at(input int i);
        if (i < q3.size()) return q3[i];
        return 8'hxx;
    endfunction

    task automatic wait_done3();
        int n = 0;
        while (done3 !== 1'b1 && n < 1400) begin @(negedge clk); n++; end
        check("d3_done_seen", done3, 1'b1);
        @(negedge clk);
    endtask

    task automatic start3(input logic [11:0] v, input logic [2:0] d, input logic [2:0] l,
                          input logic [2:0] b, input logic on, input logic blz);
        @(negedge clk);
        q3.delete();
        v3 = v; dp3 = d; led3 = l; br3 = b; on3 = on; blz3 = blz;
        req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
    endtask

    task automatic check_frame123();
        check("d3_nbytes", q3.size(), 19);
        for (int i = 0; i < 19; i++) check($sformatf("d3_byte%0d", i), q3_at(i), exp123[i]);
        check("d3_busy_len", bl_last[0], 614);
    endtask

    initial begin
        int dn_before, seen, n;
        rst3 = 1'b1; req3 = 1'b0; v3 = '0; dp3 = '0; led3 = '0; br3 = '0; on3 = 1'b0; blz3 = 1'b0;
        rst8 = 1'b1; req8 = 1'b0; v8 = '0; dp8 = '0; led8 = '0; br8 = '0; on8 = 1'b0; blz8 = 1'b0;
        repeat (3) @(negedge clk);
        rst3 = 1'b0; rst8 = 1'b0;
        check("d3_reset", {stb3, sclk3, dio3, busy3, done3}, 5'b11100);
        check("d8_reset", {stb8, sclk8, dio8, busy8, done8}, 5'b11100);

        // Basic frame 0x123
        start3(12'h123, 3'b000, 3'b000, 3'd7, 1'b1, 1'b0);
        wait_done3();
        check_frame123();
        check("d3_done_count", dn_cnt[0], 1);

        // Leading-zero blanking with a decimal point on a blanked digit
        start3(12'h007, 3'b010, 3'b000, 3'd7, 1'b1, 1'b1);
        wait_done3();
        check("lz_g0", q3_at(2), 8'h00);
        check("lz_g1", q3_at(4), 8'h80);
        check("lz_g2", q3_at(6), 8'h07);

        start3(12'h007, 3'b010, 3'b000, 3'd7, 1'b1, 1'b0);
        wait_done3();
        check("nolz_g0", q3_at(2), 8'h3F);
        check("nolz_g1", q3_at(4), 8'hBF);
        check("nolz_g2", q3_at(6), 8'h07);

        // All-zero value keeps digit 0; LEDs on odd addresses
        start3(12'h000, 3'b000, 3'b101, 3'd7, 1'b1, 1'b1);
        wait_done3();
        check("zero_g0", q3_at(2), 8'h00);
        check("zero_g1", q3_at(4), 8'h00);
        check("zero_g2", q3_at(6), 8'h3F);
        check("led_a1", q3_at(3), 8'h01);
        check("led_a3", q3_at(5), 8'h00);
        check("led_a5", q3_at(7), 8'h01);

        // Display off, brightness 3; a mid-frame request and input change must be ignored
        dn_before = dn_cnt[0];
        start3(12'h123, 3'b000, 3'b000, 3'd3, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        v3 = 12'h999; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        wait_done3();
        check("off_ctrl", q3_at(18), 8'h83);
        check("off_g0", q3_at(2), 8'h06);
        check("off_g1", q3_at(4), 8'h5B);
        repeat (20) @(negedge clk);
        check("no_requeue_busy", busy3, 1'b0);
        check("no_requeue_done", dn_cnt[0], dn_before + 1);

        // Reset in the middle of a frame
        start3(12'h123, 3'b000, 3'b000, 3'd7, 1'b1, 1'b0);
        repeat (298) @(negedge clk);
        rst3 = 1'b1;
        dn_before = dn_cnt[0];
        @(negedge clk);
        check("midrst_pins", {stb3, sclk3, dio3, busy3, done3}, 5'b11100);
        rst3 = 1'b0;
        repeat (700) @(negedge clk);
        check("midrst_no_done", dn_cnt[0], dn_before);
        check("midrst_idle", busy3, 1'b0);
        start3(12'h123, 3'b000, 3'b000, 3'd7, 1'b1, 1'b0);
        wait_done3();
        check_frame123();

        // 8 digits, CLK_DIV=1, req held high for back-to-back frames
        @(negedge clk);
        q8.delete();
        v8 = 32'h89ABCDEF; dp8 = '0; led8 = '0; br8 = 3'd7; on8 = 1'b1; blz8 = 1'b0;
        req8 = 1'b1;
        seen = 0; n = 0;
        while (seen < 3 && n < 1500) begin
            @(negedge clk);
            n++;
            if (done8 === 1'b1) seen++;
        end
        req8 = 1'b0;
        check("d8_frames", seen, 3);
        @(negedge clk);
        check("d8_idle", busy8, 1'b0);
        check("d8_busy_len", bl_last[1], 307);
        check("d8_done_count", dn_cnt[1], 3);
        for (int i = 0; i < 8; i++)
            check($sformatf("d8_grid%0d", i), (2*i+2 < q8.size()) ? q8[2*i+2] : 8'hxx, exp8grid[i]);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
